// File: rtl/spmv_mem_arb.sv
// spmv_mem_arb: shares one DCP memory request/response port among NREQ
// SpMV fetch engines.
//
// Requests are granted round-robin into a single registered output slot.
// Each issued request takes the lowest free transid. The owner of every
// busy transid is recorded so that its response can be routed back.
//
// Ports:
//   clk, rst          - sole clock, synchronous active-high reset
//   req_val/req_addr  - per-requester request (packed, ADDR_W per requester)
//   req_rdy           - one-hot grant (combinational from state + req_val)
//   mem_req_*         - registered request slot towards the DCP
//   mem_resp_*        - DCP response (cannot be backpressured)
//   resp_val/_transid/_data - registered, routed response (one-cycle pulse)
//   idle              - no transid busy and no request pending in the slot
//   err_spurious      - sticky: a response arrived for a transid not busy
module spmv_mem_arb #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 512,
  parameter int TID_N   = 64,
  parameter int MAX_OUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_val,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_rdy,
  output logic                     mem_req_val,
  input  logic                     mem_req_rdy,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [5:0]               mem_req_transid,
  input  logic                     mem_resp_val,
  input  logic [5:0]               mem_resp_transid,
  input  logic [DATA_W-1:0]        mem_resp_data,
  output logic [NREQ-1:0]          resp_val,
  output logic [5:0]               resp_transid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     idle,
  output logic                     err_spurious
);

  localparam int TID_W = 6;
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW    = $clog2(MAX_OUT + 1);

  logic [TID_N-1:0] busy;
  logic [IW-1:0]    owner       [TID_N];
  logic [CW-1:0]    outstanding [NREQ];
  logic [IW-1:0]    rr_ptr;

  logic             slot_free;
  logic             free_any;
  logic [TID_W-1:0] free_tid;
  logic             grant_any;
  logic [IW-1:0]    grant_idx;
  logic             accept;
  logic             resp_hit;
  logic [IW-1:0]    resp_owner;
  logic [NREQ-1:0]  dec_vec;

  assign slot_free  = !mem_req_val || mem_req_rdy;
  assign resp_hit   = mem_resp_val && busy[mem_resp_transid];
  assign resp_owner = owner[mem_resp_transid];
  assign idle       = (busy == {TID_N{1'b0}}) && !mem_req_val;

  // Lowest-index free transid, taken from the registered (pre-update) bitmap.
  always_comb begin
    free_any = 1'b0;
    free_tid = {TID_W{1'b0}};
    for (int t = TID_N - 1; t >= 0; t--) begin
      if (!busy[TID_W'(t)]) begin
        free_any = 1'b1;
        free_tid = TID_W'(t);
      end else begin
        free_any = free_any;
      end
    end
  end

  // Round-robin pick: descending scan so the nearest eligible requester
  // at or after rr_ptr is the one that remains selected.
  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    idx       = 0;
    sel       = {IW{1'b0}};
    grant_any = 1'b0;
    grant_idx = {IW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      sel = IW'(idx);
      if (req_val[sel] && (outstanding[sel] < CW'(MAX_OUT))) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end else begin
        grant_any = grant_any;
      end
    end
  end

  // Final grant and the per-requester decrement vector for routed responses.
  always_comb begin
    accept  = slot_free && free_any && grant_any;
    req_rdy = {NREQ{1'b0}};
    dec_vec = {NREQ{1'b0}};
    if (accept) begin
      req_rdy = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
    end else begin
      req_rdy = {NREQ{1'b0}};
    end
    if (resp_hit) begin
      dec_vec = {{(NREQ-1){1'b0}}, 1'b1} << resp_owner;
    end else begin
      dec_vec = {NREQ{1'b0}};
    end
  end

  // Request slot, transid pool, owner table, counters and response routing.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_val     <= 1'b0;
      mem_req_addr    <= {ADDR_W{1'b0}};
      mem_req_transid <= {TID_W{1'b0}};
      resp_val        <= {NREQ{1'b0}};
      resp_transid    <= {TID_W{1'b0}};
      resp_data       <= {DATA_W{1'b0}};
      err_spurious    <= 1'b0;
      busy            <= {TID_N{1'b0}};
      owner           <= '{default: {IW{1'b0}}};
      outstanding     <= '{default: {CW{1'b0}}};
      rr_ptr          <= {IW{1'b0}};
    end else begin
      if (slot_free) begin
        if (accept) begin
          mem_req_val     <= 1'b1;
          mem_req_addr    <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
          mem_req_transid <= free_tid;
        end else begin
          mem_req_val     <= 1'b0;
        end
      end

      // The freed id is always busy and the allocated id always free,
      // so these two bitmap writes never target the same bit.
      if (accept) begin
        busy[free_tid]  <= 1'b1;
        owner[free_tid] <= grant_idx;
        rr_ptr          <= (grant_idx == IW'(NREQ - 1)) ? {IW{1'b0}} : grant_idx + IW'(1);
      end
      if (resp_hit) begin
        busy[mem_resp_transid] <= 1'b0;
        resp_transid           <= mem_resp_transid;
        resp_data              <= mem_resp_data;
      end else if (mem_resp_val) begin
        err_spurious <= 1'b1;
      end
      resp_val <= dec_vec;

      // Simultaneous accept and response for one requester cancel out.
      for (int i = 0; i < NREQ; i++) begin
        if (req_rdy[IW'(i)] && !dec_vec[IW'(i)]) begin
          outstanding[IW'(i)] <= outstanding[IW'(i)] + CW'(1);
        end else if (dec_vec[IW'(i)] && !req_rdy[IW'(i)]) begin
          outstanding[IW'(i)] <= outstanding[IW'(i)] - CW'(1);
        end
      end
    end
  end

endmodule
